// File: rtl/zion_en_dff_pipe.sv
// DEPTH-stage elastic pipeline register with valid/ready handshake, global hold enable,
// synchronous flush and programmable init value. Optional occupancy counter: ZION_EN_DFF_PIPE_CNT_EN.
module zion_en_dff_pipe #(
  parameter int                  WIDTH_IN  = 8,
  parameter int                  WIDTH_OUT = 8,
  parameter int                  DEPTH     = 2,
  parameter logic [WIDTH_IN-1:0] INI_DATA  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iEn,
  input  logic                 iClr,
  input  logic                 iVld,
  output logic                 oRdy,
  input  logic [WIDTH_IN-1:0]  iDat,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic [WIDTH_OUT-1:0] oDat
`ifdef ZION_EN_DFF_PIPE_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] oCnt
`endif
);

  if (WIDTH_IN != WIDTH_OUT || DEPTH < 1) begin : g_param_err
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_en_dff_pipe: illegal parameters WIDTH_IN=%0d WIDTH_OUT=%0d DEPTH=%0d",
           WIDTH_IN, WIDTH_OUT, DEPTH);
`else
    $error("zion_en_dff_pipe: illegal parameters WIDTH_IN=%0d WIDTH_OUT=%0d DEPTH=%0d",
           WIDTH_IN, WIDTH_OUT, DEPTH);
`endif
  end

  logic [DEPTH-1:0]    vld_q;
  logic [DEPTH-1:0]    vld_d;
  logic [WIDTH_IN-1:0] dat_q [DEPTH];
  logic [WIDTH_IN-1:0] dat_d [DEPTH];
  logic [DEPTH:0]      rdy;
  logic                slack;

  // A stage is ready when any stage from it to the output is empty or the consumer
  // takes a beat; this is the unrolled form of rdy[i] = iEn & (!vld[i] | rdy[i+1]).
  always_comb begin
    slack      = iRdy;
    rdy[DEPTH] = iRdy & iEn;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      slack  = slack | ~vld_q[i];
      rdy[i] = iEn & slack;
    end
  end

  assign oRdy = rdy[0] & ~iClr;
  assign oVld = vld_q[DEPTH-1] & iEn;
  assign oDat = dat_q[DEPTH-1];

  // Data only moves with a valid beat so empty slots do not toggle the data registers.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      dat_d[i] = dat_q[i];
    end
    if (iClr) begin
      vld_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_d[i] = INI_DATA;
      end
    end else begin
      if (rdy[0]) begin
        vld_d[0] = iVld;
        if (iVld) begin
          dat_d[0] = iDat;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_d[i] = vld_q[i-1];
          if (vld_q[i-1]) begin
            dat_d[i] = dat_q[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= INI_DATA;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

`ifdef ZION_EN_DFF_PIPE_CNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          cntUp;
  logic          cntDn;

  // Both handshakes are gated by iEn, so the count holds while frozen.
  assign cntUp = iVld & oRdy;
  assign cntDn = oVld & iRdy;

  always_comb begin
    cnt_d = cnt_q;
    if (iClr) begin
      cnt_d = '0;
    end else if (cntUp && !cntDn) begin
      cnt_d = cnt_q + CW'(1);
    end else if (cntDn && !cntUp) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oCnt = cnt_q;
`endif

endmodule

// File: tb/tb_zion_en_dff_pipe.sv
// Self-checking bench for zion_en_dff_pipe: directed scenarios followed by random traffic,
// all compared against a queue-of-beats reference model.
module tb_zion_en_dff_pipe;

  localparam int         DEPTH = 3;
  localparam int         WIDTH = 8;
  localparam logic [7:0] INI   = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       iEn;
  logic       iClr;
  logic       iVld;
  logic       oRdy;
  logic [7:0] iDat;
  logic       oVld;
  logic       iRdy;
  logic [7:0] oDat;
`ifdef ZION_EN_DFF_PIPE_CNT_EN
  logic [$clog2(DEPTH+1)-1:0] oCnt;
`endif

  zion_en_dff_pipe #(
    .WIDTH_IN (WIDTH),
    .WIDTH_OUT(WIDTH),
    .DEPTH    (DEPTH),
    .INI_DATA (INI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .iEn (iEn),
    .iClr(iClr),
    .iVld(iVld),
    .oRdy(oRdy),
    .iDat(iDat),
    .oVld(oVld),
    .iRdy(iRdy),
    .oDat(oDat)
`ifdef ZION_EN_DFF_PIPE_CNT_EN
    ,
    .oCnt(oCnt)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: in-flight beats ordered oldest first, each with its stage position.
  logic [7:0] mDat[$];
  int         mPos[$];
  int         newPos[$];
  bit         mPop;
  logic [7:0] mLast = INI;
  string      phase = "init";

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s.%s: observed %0h required %0h", phase, tag, observed, expected);
    end
  endtask

  // Oldest beat leaves when it sits at the output and the consumer is ready, otherwise
  // every beat slides one slot forward unless the slot ahead stays occupied.
  function automatic void planMoves(input bit rdyIn);
    newPos.delete();
    mPop = 0;
    for (int k = 0; k < mPos.size(); k++) begin
      int p;
      int lim;
      p = mPos[k];
      if (k == 0 && p == DEPTH - 1 && rdyIn) begin
        mPop = 1;
        newPos.push_back(DEPTH);
      end else begin
        lim = (k == 0) ? DEPTH : newPos[k-1];
        newPos.push_back((p + 1 < lim) ? p + 1 : p);
      end
    end
  endfunction

  task automatic applyStimulus(input bit r, input bit en, input bit clr, input bit vld,
                               input logic [7:0] d, input bit rdyIn, output bit acc);
    bit expRdy;
    bit expVld;
    rst  = r;
    iEn  = en;
    iClr = clr;
    iVld = vld;
    iDat = d;
    iRdy = rdyIn;
    #2;
    planMoves(rdyIn);
    expRdy = en && !clr && (mPos.size() == 0 || newPos[newPos.size()-1] > 0);
    expVld = en && mPos.size() > 0 && mPos[0] == DEPTH - 1;
    if (!r) begin
      checkOutput("oVld", 32'(oVld), 32'(expVld));
      checkOutput("oRdy", 32'(oRdy), 32'(expRdy));
      checkOutput("oDat", 32'(oDat), 32'(mLast));
`ifdef ZION_EN_DFF_PIPE_CNT_EN
      checkOutput("oCnt", 32'(oCnt), 32'(mPos.size()));
`endif
    end
    acc = !r && vld && expRdy;
    @(posedge clk);
    if (r || clr) begin
      mDat.delete();
      mPos.delete();
      mLast = INI;
    end else if (en) begin
      if (mPop) begin
        void'(mDat.pop_front());
        void'(mPos.pop_front());
        void'(newPos.pop_front());
      end
      for (int k = 0; k < mPos.size(); k++) begin
        if (newPos[k] == DEPTH - 1 && mPos[k] != DEPTH - 1) begin
          mLast = mDat[k];
        end
        mPos[k] = newPos[k];
      end
      if (acc) begin
        mDat.push_back(d);
        mPos.push_back(0);
        if (DEPTH == 1) begin
          mLast = d;
        end
      end
    end
    @(negedge clk);
  endtask

  logic [7:0] v;
  bit         acc;

  initial begin
    rst  = 1'b1;
    iEn  = 1'b1;
    iClr = 1'b0;
    iVld = 1'b0;
    iDat = '0;
    iRdy = 1'b1;

    phase = "reset";
    applyStimulus(1, 1, 0, 0, 8'h00, 1, acc);
    applyStimulus(1, 1, 0, 0, 8'h00, 1, acc);
    applyStimulus(0, 1, 0, 0, 8'h00, 1, acc);
    checkOutput("oDatIni", 32'(oDat), 32'(INI));

    phase = "stream";
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 0, 1, 8'(i), 1, acc);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1, acc);

    phase = "backpressure";
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, 8'h10 + 8'(i), 0, acc);
    checkOutput("fourthRejected", 32'(acc), 32'(0));
    applyStimulus(0, 1, 0, 1, 8'h13, 1, acc);
    checkOutput("fourthAccepted", 32'(acc), 32'(1));
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1, acc);

    phase = "bubble";
    applyStimulus(0, 1, 0, 1, 8'h20, 0, acc);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, acc);
    applyStimulus(0, 1, 0, 1, 8'h21, 0, acc);
    applyStimulus(0, 1, 0, 0, 8'h00, 0, acc);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1, acc);

    phase = "hold";
    v = 8'h40;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(0, !(c >= 4 && c < 8), 0, 1, v, 1, acc);
      if (acc) v++;
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1, acc);

    phase = "flush";
    applyStimulus(0, 1, 0, 1, 8'h50, 0, acc);
    applyStimulus(0, 1, 0, 1, 8'h51, 0, acc);
    applyStimulus(0, 1, 1, 1, 8'h33, 0, acc);
    checkOutput("flushBeatDropped", 32'(acc), 32'(0));
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1, acc);
    checkOutput("oDatAfterFlush", 32'(oDat), 32'(INI));

    phase = "random";
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
                    8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
